alu_ab_datapath: RTL and testbench



---
 rtl/alu_ab_datapath.sv | 209 ++++++++++++++++++++
 tb/tb_alu_ab_datapath.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ab_datapath.sv
// alu_ab_datapath: 4-bit accumulator datapath with an A register, a B register,
// a combinational ALU and registered zero/carry flags. A and B load from RAM,
// from TMP, from each other, or from the ALU result under control strobes.
// Output enables are combinational. A disabled output drives zero, so the
// surrounding buses can be OR-combined without tri-states.
//
// Build option: define ALU_SHIFT_EN to add SHL (1100) and SHR (1101).
// Without it, those two opcodes behave as NOPs.
module alu_ab_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] ram_to_a,
    input  logic [WIDTH-1:0] tmp_to_b,
    input  logic [WIDTH-1:0] tmp_to_alu,
    input  logic [WIDTH-1:0] ram_to_b,
    input  logic             carry_in,
    input  logic             la_ram,
    input  logic             la_b,
    input  logic             la_alu,
    input  logic             lb_tmp,
    input  logic             lb_alu,
    input  logic             lb_pop,
    input  logic             lb_carry,
    input  logic             b_rcl,
    input  logic             alu_en,
    input  logic             ea_tmp,
    input  logic             ea_ram,
    input  logic             ea_out,
    input  logic             ea_carry,
    input  logic             eb_a,
    input  logic             eb_push,
    output logic [WIDTH-1:0] a_to_tmp,
    output logic [WIDTH-1:0] a_to_ram,
    output logic [WIDTH-1:0] a_to_out,
    output logic [WIDTH-1:0] b_to_a,
    output logic [WIDTH-1:0] b_to_ram,
    output logic [WIDTH-1:0] a_to_alu,
    output logic [WIDTH-1:0] b_to_alu,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             carry_from_a,
    output logic             carry_from_b
);

    // Opcode encodings (instruction register high nibble)
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADDT = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOT  = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_CMP  = 4'b1110;

    // Architectural state
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_zero_flag;
    logic             r_carry_flag;
    logic             r_carry_from_a;
    logic             r_carry_from_b;

    // ALU internals
    logic [WIDTH:0]   w_add_ab;
    logic [WIDTH:0]   w_add_at;
    logic [WIDTH:0]   w_sub_ab;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_op_valid;   // opcode is a real ALU op (updates flags)
    logic             w_op_writes;  // op result may be written back (not CMP)
    logic             w_alu_fire;
    logic             w_a_alu_wr;
    logic             w_b_alu_wr;

    // Widened adders so the top bit is the carry (add) or borrow (sub)
    assign w_add_ab = {1'b0, r_a} + {1'b0, r_b};
    assign w_add_at = {1'b0, r_a} + {1'b0, tmp_to_alu};
    assign w_sub_ab = {1'b0, r_a} - {1'b0, r_b};

    // ALU: decode opcode into result, carry and writeback qualifiers
    always_comb begin
        w_result    = '0;
        w_carry     = 1'b0;
        w_op_valid  = 1'b1;
        w_op_writes = 1'b1;
        case (opcode)
            OP_ADD: begin
                w_result = w_add_ab[WIDTH-1:0];
                w_carry  = w_add_ab[WIDTH];
            end
            OP_SUB: begin
                w_result = w_sub_ab[WIDTH-1:0];
                w_carry  = w_sub_ab[WIDTH];
            end
            OP_ADDT: begin
                w_result = w_add_at[WIDTH-1:0];
                w_carry  = w_add_at[WIDTH];
            end
            OP_AND: w_result = r_a & r_b;
            OP_OR:  w_result = r_a | r_b;
            OP_XOR: w_result = r_a ^ r_b;
            OP_NOT: w_result = ~r_a;
            OP_CMP: begin
                // Compare sets flags like SUB but never writes a register
                w_result    = w_sub_ab[WIDTH-1:0];
                w_carry     = w_sub_ab[WIDTH];
                w_op_writes = 1'b0;
            end
`ifdef ALU_SHIFT_EN
            OP_SHL: begin
                w_result = {r_a[WIDTH-2:0], 1'b0};
                w_carry  = r_a[WIDTH-1];
            end
            OP_SHR: begin
                w_result = {1'b0, r_a[WIDTH-1:1]};
                w_carry  = r_a[0];
            end
`else
            OP_SHL, OP_SHR: begin
                w_op_valid  = 1'b0;
                w_op_writes = 1'b0;
            end
`endif
            default: begin
                w_op_valid  = 1'b0;
                w_op_writes = 1'b0;
            end
        endcase
    end

    // Register writes from the ALU only occur on a strobed, writing op
    assign w_alu_fire = alu_en & w_op_valid;
    assign w_a_alu_wr = w_alu_fire & w_op_writes & la_alu;
    assign w_b_alu_wr = w_alu_fire & w_op_writes & lb_alu;

    // A register: ALU write beats RAM load, which beats the B transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a <= '0;
        end else if (w_a_alu_wr) begin
            r_a <= w_result;
        end else if (la_ram) begin
            r_a <= ram_to_a;
        end else if (la_b) begin
            r_a <= r_b;
        end
    end

    // B register: ALU > pop > TMP > carry-load > rotate-left-through-carry
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_b            <= '0;
            r_carry_from_b <= 1'b0;
        end else if (w_b_alu_wr) begin
            r_b <= w_result;
        end else if (lb_pop) begin
            r_b <= ram_to_b;
        end else if (lb_tmp) begin
            r_b <= tmp_to_b;
        end else if (lb_carry) begin
            r_b <= {{(WIDTH-1){1'b0}}, carry_in};
        end else if (b_rcl) begin
            // The shifted-out bit is only captured when the rotate takes effect
            r_b            <= {r_b[WIDTH-2:0], carry_in};
            r_carry_from_b <= r_b[WIDTH-1];
        end
    end

    // Flags update on every strobed valid op, including CMP
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_zero_flag  <= 1'b0;
            r_carry_flag <= 1'b0;
        end else if (w_alu_fire) begin
            r_zero_flag  <= (w_result == '0);
            r_carry_flag <= w_carry;
        end
    end

    // Capture A's top bit when the A carry output is enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_carry_from_a <= 1'b0;
        end else if (ea_carry) begin
            r_carry_from_a <= r_a[WIDTH-1];
        end
    end

    // Gated bus outputs: a disabled enable drives zero
    assign a_to_tmp = ea_tmp  ? r_a : '0;
    assign a_to_ram = ea_ram  ? r_a : '0;
    assign a_to_out = ea_out  ? r_a : '0;
    assign b_to_a   = eb_a    ? r_b : '0;
    assign b_to_ram = eb_push ? r_b : '0;

    // Always-visible operands and registered flags
    assign a_to_alu     = r_a;
    assign b_to_alu     = r_b;
    assign zero_flag    = r_zero_flag;
    assign carry_flag   = r_carry_flag;
    assign carry_from_a = r_carry_from_a;
    assign carry_from_b = r_carry_from_b;

endmodule

// File: tb/tb_alu_ab_datapath.sv
// Testbench for alu_ab_datapath: directed scenarios followed by random cycles,
// all compared against a behavioural model built from integer arithmetic.
module tb_alu_ab_datapath;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] opcode, ram_to_a, tmp_to_b, tmp_to_alu, ram_to_b;
    logic       carry_in, la_ram, la_b, la_alu, lb_tmp, lb_alu, lb_pop, lb_carry, b_rcl;
    logic       alu_en, ea_tmp, ea_ram, ea_out, ea_carry, eb_a, eb_push;
    logic [3:0] a_to_tmp, a_to_ram, a_to_out, b_to_a, b_to_ram, a_to_alu, b_to_alu;
    logic       zero_flag, carry_flag, carry_from_a, carry_from_b;

    alu_ab_datapath #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .ram_to_a(ram_to_a), .tmp_to_b(tmp_to_b), .tmp_to_alu(tmp_to_alu), .ram_to_b(ram_to_b),
        .carry_in(carry_in), .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
        .lb_tmp(lb_tmp), .lb_alu(lb_alu), .lb_pop(lb_pop), .lb_carry(lb_carry), .b_rcl(b_rcl),
        .alu_en(alu_en), .ea_tmp(ea_tmp), .ea_ram(ea_ram), .ea_out(ea_out), .ea_carry(ea_carry),
        .eb_a(eb_a), .eb_push(eb_push),
        .a_to_tmp(a_to_tmp), .a_to_ram(a_to_ram), .a_to_out(a_to_out),
        .b_to_a(b_to_a), .b_to_ram(b_to_ram), .a_to_alu(a_to_alu), .b_to_alu(b_to_alu),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .carry_from_a(carry_from_a), .carry_from_b(carry_from_b)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_a, m_b, m_z, m_c, m_cfa, m_cfb;

    // Next-state of the datapath from the architectural rules, in plain integers
    task automatic model_step();
        int  res;
        int  cy;
        bit  valid;
        bit  wb;
        bit  fire;
        int  na;
        int  nb;
        int  ncfb;
        res = 0; cy = 0; valid = 1; wb = 1;
        case (int'(opcode))
            1:  begin res = m_a + m_b;          cy = (res > 15) ? 1 : 0; end
            2:  begin res = m_a - m_b;          cy = (m_a < m_b) ? 1 : 0; end
            4:  begin res = m_a + int'(tmp_to_alu); cy = (res > 15) ? 1 : 0; end
            8:  res = m_a & m_b;
            9:  res = m_a | m_b;
            10: res = m_a ^ m_b;
            11: res = 15 - m_a;
            14: begin res = m_a - m_b; cy = (m_a < m_b) ? 1 : 0; wb = 0; end
`ifdef ALU_SHIFT_EN
            12: begin res = m_a * 2; cy = (m_a >= 8) ? 1 : 0; end
            13: begin res = m_a / 2; cy = m_a % 2; end
`endif
            default: begin valid = 0; wb = 0; end
        endcase
        res = res & 15;
        if (!reset) begin
            m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_cfa = 0; m_cfb = 0;
            return;
        end
        fire = alu_en && valid;
        na = m_a;
        if (fire && wb && la_alu) na = res;
        else if (la_ram)          na = int'(ram_to_a);
        else if (la_b)            na = m_b;
        nb = m_b;
        ncfb = m_cfb;
        if (fire && wb && lb_alu) nb = res;
        else if (lb_pop)          nb = int'(ram_to_b);
        else if (lb_tmp)          nb = int'(tmp_to_b);
        else if (lb_carry)        nb = int'(carry_in);
        else if (b_rcl) begin
            nb   = (m_b * 2 + int'(carry_in)) % 16;
            ncfb = (m_b >= 8) ? 1 : 0;
        end
        if (ea_carry) m_cfa = (m_a >= 8) ? 1 : 0;
        if (fire) begin
            m_z = (res == 0) ? 1 : 0;
            m_c = cy;
        end
        m_a = na; m_b = nb; m_cfb = ncfb;
    endtask

    task automatic check_comb();
        check("a_to_tmp", int'(a_to_tmp), ea_tmp  ? m_a : 0);
        check("a_to_ram", int'(a_to_ram), ea_ram  ? m_a : 0);
        check("a_to_out", int'(a_to_out), ea_out  ? m_a : 0);
        check("b_to_a",   int'(b_to_a),   eb_a    ? m_b : 0);
        check("b_to_ram", int'(b_to_ram), eb_push ? m_b : 0);
    endtask

    task automatic check_state();
        check("reg_a",        int'(a_to_alu),     m_a);
        check("reg_b",        int'(b_to_alu),     m_b);
        check("zero_flag",    int'(zero_flag),    m_z);
        check("carry_flag",   int'(carry_flag),   m_c);
        check("carry_from_a", int'(carry_from_a), m_cfa);
        check("carry_from_b", int'(carry_from_b), m_cfb);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        reset = 1'b1; opcode = 4'd0;
        ram_to_a = 4'd0; tmp_to_b = 4'd0; tmp_to_alu = 4'd0; ram_to_b = 4'd0;
        carry_in = 1'b0; la_ram = 1'b0; la_b = 1'b0; la_alu = 1'b0;
        lb_tmp = 1'b0; lb_alu = 1'b0; lb_pop = 1'b0; lb_carry = 1'b0; b_rcl = 1'b0;
        alu_en = 1'b0; ea_tmp = 1'b0; ea_ram = 1'b0; ea_out = 1'b0; ea_carry = 1'b0;
        eb_a = 1'b0; eb_push = 1'b0;
    endtask

    // One clock: inputs already driven; check comb outputs, advance, check state
    task automatic cycle();
        #1;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        idle();
        la_ram = 1'b1; ram_to_a = a;
        lb_tmp = 1'b1; tmp_to_b = b;
        cycle();
        idle();
    endtask

    task automatic exec(input logic [3:0] op, input logic wa, input logic wbb);
        idle();
        opcode = op; alu_en = 1'b1; la_alu = wa; lb_alu = wbb;
        cycle();
        idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        m_a = 0; m_b = 0; m_z = 0; m_c = 0; m_cfa = 0; m_cfb = 0;
        @(posedge clk); #1;

        // Reset from a non-zero state
        reset = 1'b0; cycle(); idle();
        load_ab(4'd5, 4'd3);
        check("pre_reset_a", int'(a_to_alu), 5);
        reset = 1'b0; ea_tmp = 1'b1; ea_ram = 1'b1; ea_out = 1'b1; eb_a = 1'b1; eb_push = 1'b1;
        la_ram = 1'b1; ram_to_a = 4'd7; cycle();
        reset = 1'b1; la_ram = 1'b0; #1;
        check("rst_a", int'(a_to_alu), 0);
        check("rst_b", int'(b_to_alu), 0);
        check("rst_z", int'(zero_flag), 0);
        check("rst_c", int'(carry_flag), 0);
        check("rst_out", int'(a_to_out), 0);
        check("rst_push", int'(b_to_ram), 0);
        idle();

        // AND
        load_ab(4'd5, 4'd3);
        exec(4'b1000, 1'b1, 1'b0);
        check("and_a", int'(a_to_alu), 1);
        check("and_z", int'(zero_flag), 0);
        check("and_c", int'(carry_flag), 0);

        // ADD overflow, SUB to zero
        load_ab(4'd9, 4'd8);
        exec(4'b0001, 1'b1, 1'b0);
        check("add_a", int'(a_to_alu), 1);
        check("add_c", int'(carry_flag), 1);
        load_ab(4'd3, 4'd3);
        exec(4'b0010, 1'b1, 1'b0);
        check("sub_a", int'(a_to_alu), 0);
        check("sub_z", int'(zero_flag), 1);

        // Exchange path
        load_ab(4'd3, 4'd0);
        la_b = 1'b1; eb_a = 1'b1; #1;
        check("xchg_bus", int'(b_to_a), 0);
        cycle(); idle();
        check("xchg_a", int'(a_to_alu), 0);
        lb_tmp = 1'b1; tmp_to_b = 4'd3; cycle(); idle();
        check("xchg_b", int'(b_to_alu), 3);

        // CMP then NOP
        load_ab(4'd4, 4'd4);
        exec(4'b1110, 1'b1, 1'b1);
        check("cmp_z", int'(zero_flag), 1);
        check("cmp_a", int'(a_to_alu), 4);
        check("cmp_b", int'(b_to_alu), 4);
        exec(4'b0000, 1'b1, 1'b1);
        check("nop_z", int'(zero_flag), 1);
        check("nop_c", int'(carry_flag), 0);

        // Rotate and carry load
        load_ab(4'd0, 4'b1001);
        b_rcl = 1'b1; carry_in = 1'b0; cycle(); idle();
        check("rcl_b", int'(b_to_alu), 2);
        check("rcl_cfb", int'(carry_from_b), 1);
        lb_carry = 1'b1; carry_in = 1'b1; cycle(); idle();
        check("lbc_b", int'(b_to_alu), 1);

        // ea_carry capture
        load_ab(4'd12, 4'd0);
        ea_carry = 1'b1; cycle(); idle();
        check("cfa", int'(carry_from_a), 1);

        // Random cycles against the model
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 31) != 0);
            opcode     = 4'($urandom_range(0, 15));
            ram_to_a   = 4'($urandom_range(0, 15));
            tmp_to_b   = 4'($urandom_range(0, 15));
            tmp_to_alu = 4'($urandom_range(0, 15));
            ram_to_b   = 4'($urandom_range(0, 15));
            carry_in   = 1'($urandom_range(0, 1));
            la_ram     = ($urandom_range(0, 5) == 0);
            la_b       = ($urandom_range(0, 5) == 0);
            la_alu     = ($urandom_range(0, 1) == 0);
            lb_tmp     = ($urandom_range(0, 5) == 0);
            lb_alu     = ($urandom_range(0, 2) == 0);
            lb_pop     = ($urandom_range(0, 7) == 0);
            lb_carry   = ($urandom_range(0, 7) == 0);
            b_rcl      = ($urandom_range(0, 3) == 0);
            alu_en     = ($urandom_range(0, 1) == 0);
            ea_tmp     = ($urandom_range(0, 1) == 0);
            ea_ram     = ($urandom_range(0, 1) == 0);
            ea_out     = ($urandom_range(0, 1) == 0);
            ea_carry   = ($urandom_range(0, 2) == 0);
            eb_a       = ($urandom_range(0, 1) == 0);
            eb_push    = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
